bus_arbiter_rr: RTL and testbench

- Round-robin arbiter that shares one internal data bus between NUM_REQ drivers.
- Each driver reaches the bus through a buffer/tri-state driver; this block generates those driver enables.
- Guarantees at most one enabled driver per cycle, a bounded hold time, and idle turnaround cycles between owners.
- Sits between the CPU datapath units (ALU, memory read port, register file, immediate source) and the shared bus.

---
 rtl/bus_arb_pkg.sv | 32 +++
 rtl/bus_arbiter_rr_picker.sv | 30 +++
 rtl/bus_arbiter_rr.sv | 133 +++++++++++++
 tb/tb_bus_arbiter_rr.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared definitions for the round-robin bus arbiter: FSM encoding, default
// parameter values and the one-hot to index helper.
`default_nettype none

package bus_arb_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      GRANT      = 2'd1,
      TURNAROUND = 2'd2
   } arb_state_t;

   localparam int DEF_NUM_REQ     = 4;
   localparam int DEF_MAX_HOLD    = 16;
   localparam int DEF_TURN_CYCLES = 1;
   localparam int DEF_ID_W        = 2;

   // Supports up to 8 requesters; callers zero-extend narrower vectors.
   function automatic logic [2:0] onehot_to_idx(input logic [7:0] onehot);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (onehot[i]) begin
            idx = 3'(i);
         end
      end
      return idx;
   endfunction

endpackage

`default_nettype wire

// File: rtl/bus_arbiter_rr_picker.sv
// rr_priority_picker: combinational round-robin search starting one above ptr.
`default_nettype none

module rr_priority_picker #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] winner,
   output logic               valid
);

   always_comb begin
      logic [ID_W-1:0] idx;
      winner = '0;
      valid  = 1'b0;
      idx    = '0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         idx = ID_W'((int'(ptr) + off) % NUM_REQ);
         if (!valid && req[idx]) begin
            winner[idx] = 1'b1;
            valid       = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: round-robin owner of a shared bus with bounded hold time
// and all-drivers-off turnaround cycles between owners.
`default_nettype none

module bus_arbiter_rr
   import bus_arb_pkg::*;
#(
   parameter int NUM_REQ     = DEF_NUM_REQ,
   parameter int MAX_HOLD    = DEF_MAX_HOLD,
   parameter int TURN_CYCLES = DEF_TURN_CYCLES,
   parameter int ID_W        = DEF_ID_W
) (
   input  logic               GlobalClock,
   input  logic               Reset_n,
   input  logic [NUM_REQ-1:0] Req,
   output logic [NUM_REQ-1:0] Grant,
   output logic [NUM_REQ-1:0] Bus_Enable,
   output logic [ID_W-1:0]    Grant_Id,
   output logic               Bus_Busy,
   output logic               Preempt
);

   localparam logic [ID_W-1:0] PTR_RESET  = ID_W'(NUM_REQ - 1);
   localparam logic [7:0]      HOLD_LIMIT = 8'(MAX_HOLD);
   localparam logic [1:0]      TURN_LIMIT = 2'(TURN_CYCLES);

   arb_state_t         state;
   logic [ID_W-1:0]    ptr;
   logic [7:0]         hold_cnt;
   logic [1:0]         turn_cnt;
   logic [NUM_REQ-1:0] grant_q;
   logic [ID_W-1:0]    grant_id_q;
   logic               busy_q;
   logic               preempt_q;

   logic [NUM_REQ-1:0] pick_onehot;
   logic               pick_valid;
   logic [ID_W-1:0]    pick_id;
   logic               owner_req;

   rr_priority_picker #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_picker (
      .req    (Req),
      .ptr    (ptr),
      .winner (pick_onehot),
      .valid  (pick_valid)
   );

   assign pick_id   = ID_W'(onehot_to_idx(8'(pick_onehot)));
   assign owner_req = |(Req & grant_q);

   always_ff @(posedge GlobalClock or negedge Reset_n) begin
      if (!Reset_n) begin
         state      <= IDLE;
         ptr        <= PTR_RESET;
         hold_cnt   <= 8'd0;
         turn_cnt   <= 2'd0;
         grant_q    <= '0;
         grant_id_q <= '0;
         busy_q     <= 1'b0;
         preempt_q  <= 1'b0;
      end else begin
         preempt_q <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  state      <= GRANT;
                  grant_q    <= pick_onehot;
                  grant_id_q <= pick_id;
                  hold_cnt   <= 8'd1;
                  busy_q     <= 1'b1;
               end else begin
                  grant_q    <= '0;
                  grant_id_q <= '0;
                  busy_q     <= 1'b0;
               end
            end
            GRANT: begin
               // A still-requesting owner leaving here can only mean the hold limit hit.
               if (!owner_req || (hold_cnt >= HOLD_LIMIT)) begin
                  state      <= TURNAROUND;
                  ptr        <= grant_id_q;
                  grant_q    <= '0;
                  grant_id_q <= '0;
                  hold_cnt   <= 8'd0;
                  turn_cnt   <= 2'd1;
                  busy_q     <= 1'b1;
                  preempt_q  <= owner_req;
               end else begin
                  hold_cnt <= hold_cnt + 8'd1;
               end
            end
            TURNAROUND: begin
               if (turn_cnt >= TURN_LIMIT) begin
                  turn_cnt <= 2'd0;
                  if (pick_valid) begin
                     state      <= GRANT;
                     grant_q    <= pick_onehot;
                     grant_id_q <= pick_id;
                     hold_cnt   <= 8'd1;
                     busy_q     <= 1'b1;
                  end else begin
                     state  <= IDLE;
                     busy_q <= 1'b0;
                  end
               end else begin
                  turn_cnt <= turn_cnt + 2'd1;
               end
            end
            default: begin
               state      <= IDLE;
               ptr        <= PTR_RESET;
               hold_cnt   <= 8'd0;
               turn_cnt   <= 2'd0;
               grant_q    <= '0;
               grant_id_q <= '0;
               busy_q     <= 1'b0;
            end
         endcase
      end
   end

   assign Grant      = grant_q;
   assign Bus_Enable = grant_q;
   assign Grant_Id   = grant_id_q;
   assign Bus_Busy   = busy_q;
   assign Preempt    = preempt_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr: directed scenarios plus random traffic
// against an owner/gap reference model.
`default_nettype none

module tb_bus_arbiter_rr;

   localparam int N    = 4;
   localparam int HOLD = 16;
   localparam int TURN = 1;
   localparam int IDW  = 2;

   logic           GlobalClock = 1'b0;
   logic           Reset_n;
   logic [N-1:0]   Req;
   logic [N-1:0]   Grant;
   logic [N-1:0]   Bus_Enable;
   logic [IDW-1:0] Grant_Id;
   logic           Bus_Busy;
   logic           Preempt;

   int passed = 0;
   int total  = 0;
   int failed = 0;

   // Reference model: who owns the bus, how long, and how much idle gap is left.
   int m_owner;
   int m_held;
   int m_gap;
   int m_last;
   bit m_pre;

   bus_arbiter_rr #(
      .NUM_REQ     (N),
      .MAX_HOLD    (HOLD),
      .TURN_CYCLES (TURN),
      .ID_W        (IDW)
   ) dut (
      .GlobalClock (GlobalClock),
      .Reset_n     (Reset_n),
      .Req         (Req),
      .Grant       (Grant),
      .Bus_Enable  (Bus_Enable),
      .Grant_Id    (Grant_Id),
      .Bus_Busy    (Bus_Busy),
      .Preempt     (Preempt)
   );

   always #5 GlobalClock = ~GlobalClock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_held  = 0;
      m_gap   = 0;
      m_last  = N - 1;
      m_pre   = 1'b0;
   endtask

   task automatic model_pick(input logic [N-1:0] r);
      for (int k = 1; k <= N; k++) begin
         int c;
         c = (m_last + k) % N;
         if (m_owner < 0 && r[c]) begin
            m_owner = c;
            m_held  = 1;
         end
      end
   endtask

   task automatic model_step(input logic [N-1:0] r);
      m_pre = 1'b0;
      if (m_owner >= 0) begin
         if (!r[m_owner] || m_held == HOLD) begin
            m_pre   = r[m_owner];
            m_last  = m_owner;
            m_owner = -1;
            m_gap   = TURN;
         end else begin
            m_held++;
         end
      end else if (m_gap > 0) begin
         m_gap--;
         if (m_gap == 0) model_pick(r);
      end else begin
         model_pick(r);
      end
   endtask

   task automatic check_all(input string tag);
      logic [N-1:0]   eg;
      logic [IDW-1:0] eid;
      eg  = (m_owner >= 0) ? N'(1 << m_owner) : '0;
      eid = (m_owner >= 0) ? IDW'(m_owner) : '0;
      check({tag, ".grant"}, 32'(Grant), 32'(eg));
      check({tag, ".enable"}, 32'(Bus_Enable), 32'(eg));
      check({tag, ".id"}, 32'(Grant_Id), 32'(eid));
      check({tag, ".busy"}, 32'(Bus_Busy), 32'((m_owner >= 0) || (m_gap > 0)));
      check({tag, ".preempt"}, 32'(Preempt), 32'(m_pre));
      check({tag, ".onehot"}, 32'($countones(Bus_Enable) <= 1), 32'd1);
   endtask

   task automatic cycle(input logic [N-1:0] r, input string tag);
      Req = r;
      @(posedge GlobalClock);
      model_step(r);
      #1;
      check_all(tag);
   endtask

   initial begin
      int gcount;
      int bound;
      logic [31:0] rnd;

      // Reset with everyone requesting: nothing may be granted.
      Reset_n = 1'b0;
      Req     = 4'b1111;
      model_reset();
      repeat (3) @(posedge GlobalClock);
      #1;
      check_all("reset");
      Reset_n = 1'b1;
      cycle(4'b1111, "first");
      check("first_grant", 32'(Grant), 32'h1);

      // Rotation: each owner holds 3 cycles then drops for one edge.
      for (int k = 0; k < 4; k++) begin
         logic [N-1:0] drop;
         drop = 4'b1111;
         drop[k] = 1'b0;
         cycle(4'b1111, "rot");
         cycle(4'b1111, "rot");
         cycle(drop, "rot_rel");
         check("rot_gap", 32'(Bus_Enable), 32'h0);
         cycle(4'b1111, "rot_next");
         check("rot_owner", 32'(Grant_Id), 32'((k + 1) % 4));
      end
      cycle(4'b0000, "drain");
      cycle(4'b0000, "drain");
      check("drain_idle", 32'(Bus_Busy), 32'h0);

      // Continuous single requester hits the hold limit.
      cycle(4'b0100, "hold");
      gcount = 1;
      bound  = 0;
      while (Preempt !== 1'b1 && bound < 40) begin
         cycle(4'b0100, "hold");
         if (Grant === 4'b0100) gcount++;
         bound++;
      end
      check("hold_bound", 32'(bound < 40), 32'd1);
      check("hold_len", 32'(gcount), 32'(HOLD));
      check("hold_pre_grant", 32'(Grant), 32'h0);
      cycle(4'b0100, "regrant");
      check("regrant_id", 32'(Grant), 32'h4);
      cycle(4'b0000, "drain");
      cycle(4'b0000, "drain");

      // Release on the same edge the hold limit is reached.
      cycle(4'b0010, "simul");
      repeat (HOLD - 1) cycle(4'b0010, "simul");
      cycle(4'b0000, "simul_rel");
      check("simul_nopre", 32'(Preempt), 32'h0);
      check("simul_busy", 32'(Bus_Busy), 32'h1);
      cycle(4'b0000, "simul_idle");
      check("simul_idle_busy", 32'(Bus_Busy), 32'h0);

      // Turnaround re-arbitrates straight into a new grant.
      cycle(4'b1000, "rearb");
      cycle(4'b1001, "rearb");
      cycle(4'b1001, "rearb");
      cycle(4'b0001, "rearb_rel");
      check("rearb_turn_busy", 32'(Bus_Busy), 32'h1);
      cycle(4'b1001, "rearb_new");
      check("rearb_owner", 32'(Grant), 32'h1);
      check("rearb_busy", 32'(Bus_Busy), 32'h1);
      cycle(4'b0000, "drain");
      cycle(4'b0000, "drain");

      // Asynchronous reset between edges while owner 1 holds the bus.
      cycle(4'b0010, "areset_pre");
      check("areset_owner", 32'(Grant), 32'h2);
      #2;
      Reset_n = 1'b0;
      #1;
      model_reset();
      check_all("areset");
      Req = 4'b1111;
      @(posedge GlobalClock);
      #1;
      Reset_n = 1'b1;
      cycle(4'b1111, "areset_after");
      check("areset_prio", 32'(Grant), 32'h1);

      // Random traffic with sticky requests so owners hold for a while.
      Req = 4'b0000;
      for (int i = 0; i < 600; i++) begin
         logic [N-1:0] r;
         rnd = $urandom();
         r = Req;
         if (rnd[31:30] == 2'b00) r = rnd[3:0];
         else if (rnd[29:27] == 3'b000) r = r & rnd[7:4];
         cycle(r, "rand");
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire
